// File: rtl/div_timer_pkg.sv
// Shared types and defaults for the tick-driven down-counting timer.
package div_timer_pkg;

  localparam int unsigned SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: one-cycle strobe when d goes 0 -> 1.
// A level held high produces a single strobe.
module edge_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  // Delay the level by one cycle for edge comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/div_tick_timer.sv
// Programmable down-counter driven by the upstream terminal-count strobe.
// Counts load_val+1 tick events, then pulses done; one-shot or auto-reload.
module div_tick_timer
  import div_timer_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tc_in,
  input  logic            start,
  input  logic            stop,
  input  logic            clear,
  input  logic            periodic,
  input  logic [SIZE-1:0] load_val,
  output logic [SIZE-1:0] count,
  output logic            running,
  output logic            done,
  output logic            expired
);

  state_t          state_q;
  state_t          state_d;
  logic [SIZE-1:0] count_d;
  logic [SIZE-1:0] reload_q;
  logic [SIZE-1:0] reload_d;
  logic            mode_q;
  logic            mode_d;
  logic            running_d;
  logic            done_d;
  logic            expired_d;
  logic            tick;

  edge_rise_det u_tick_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (tc_in),
    .rise_c (tick)
  );

  // Next-state and next-output decode; priority stop > start > tick > clear
  always_comb begin
    state_d   = state_q;
    count_d   = count;
    reload_d  = reload_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    expired_d = expired;

    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d   = ST_RUN;
      count_d   = load_val;
      reload_d  = load_val;
      mode_d    = periodic;
      expired_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear) expired_d = 1'b0;
        end
        ST_RUN: begin
          if (tick) begin
            if (count != '0) begin
              count_d = count - SIZE'(1);
            end else if (mode_q) begin
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              expired_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (clear) begin
            state_d   = ST_IDLE;
            expired_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  // State, counter and captured configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      running  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      running  <= running_d;
    end
  end

  // Expiry flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done    <= done_d;
      expired <= expired_d;
    end
  end

endmodule

// File: tb/tb_div_tick_timer.sv
// Scenario bench for div_tick_timer: each vector carries its stimulus and the
// outputs expected one clock later; expectations queue on drive and are
// popped and compared after the edge.
module tb_div_tick_timer;

  localparam int unsigned SIZE = 8;

  logic            clk;
  logic            rst_n;
  logic            tc_in;
  logic            start;
  logic            stop;
  logic            clear;
  logic            periodic;
  logic [SIZE-1:0] load_val;
  logic [SIZE-1:0] count;
  logic            running;
  logic            done;
  logic            expired;

  typedef struct {
    logic            tc;
    logic            st;
    logic            sp;
    logic            cl;
    logic            per;
    logic [SIZE-1:0] ld;
    logic [SIZE-1:0] ecount;
    logic            erun;
    logic            edone;
    logic            eexp;
  } vec_t;

  typedef struct {
    logic [SIZE-1:0] count;
    logic            running;
    logic            done;
    logic            expired;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   vectors;
  int   miscompares;

  div_tick_timer #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tc_in    (tc_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .periodic (periodic),
    .load_val (load_val),
    .count    (count),
    .running  (running),
    .done     (done),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic tc, input logic st, input logic sp,
                              input logic cl, input logic per, input int ld,
                              input int ec, input logic er, input logic ed,
                              input logic ee);
    vec_t v;
    v.tc = tc; v.st = st; v.sp = sp; v.cl = cl; v.per = per;
    v.ld = SIZE'(ld); v.ecount = SIZE'(ec);
    v.erun = er; v.edone = ed; v.eexp = ee;
    return v;
  endfunction

  // Apply one vector for one clock, queue its expectation, sample #1 after edge
  task automatic drive(input vec_t v);
    exp_t e;
    tc_in = v.tc; start = v.st; stop = v.sp; clear = v.cl;
    periodic = v.per; load_val = v.ld;
    e.count = v.ecount; e.running = v.erun; e.done = v.edone; e.expired = v.eexp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; tc_in = 0; start = 0; stop = 0; clear = 0; periodic = 0; load_val = '0;
    #1;
    e.count = '0; e.running = 0; e.done = 0; e.expired = 0;
    sb.push_back(e);
    e = sb.pop_front();
    vectors++;
    if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
      miscompares++;
      $display("FAIL reset_in: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
               count, running, done, expired, e.count, e.running, e.done, e.expired);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
    for (int i = 0; vq.size() > 0; i++) begin
      drive(vq.pop_front());
      e = sb.pop_front();
      vectors++;
      if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
        miscompares++;
        $display("FAIL reset step %0d: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
                 i, count, running, done, expired, e.count, e.running, e.done, e.expired);
      end
    end
  endtask

  task automatic test_one_shot();
    exp_t e;
    vq.push_back(mk(0,1,0,0,0,3, 3,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 2,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 2,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,1));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,1));
    vq.push_back(mk(0,0,0,1,0,0, 0,0,0,0));
    for (int i = 0; vq.size() > 0; i++) begin
      drive(vq.pop_front());
      e = sb.pop_front();
      vectors++;
      if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
        miscompares++;
        $display("FAIL one_shot step %0d: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
                 i, count, running, done, expired, e.count, e.running, e.done, e.expired);
      end
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    vq.push_back(mk(0,1,0,0,1,1, 1,1,0,0));
    for (int t = 1; t <= 6; t++) begin
      vq.push_back(mk(1,0,0,0,0,0, (t % 2 == 1) ? 0 : 1, 1, (t % 2 == 0), 0));
      vq.push_back(mk(0,0,0,0,0,0, (t % 2 == 1) ? 0 : 1, 1, 0, 0));
    end
    vq.push_back(mk(0,0,1,0,0,0, 1,0,0,0));
    for (int i = 0; vq.size() > 0; i++) begin
      drive(vq.pop_front());
      e = sb.pop_front();
      vectors++;
      if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
        miscompares++;
        $display("FAIL periodic step %0d: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
                 i, count, running, done, expired, e.count, e.running, e.done, e.expired);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    vq.push_back(mk(0,1,0,0,0,2, 2,1,0,0));
    repeat (5) vq.push_back(mk(1,0,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0, 1,0,0,0));
    for (int i = 0; vq.size() > 0; i++) begin
      drive(vq.pop_front());
      e = sb.pop_front();
      vectors++;
      if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
        miscompares++;
        $display("FAIL stall step %0d: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
                 i, count, running, done, expired, e.count, e.running, e.done, e.expired);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    vq.push_back(mk(0,1,0,0,0,5, 5,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 4,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 4,1,0,0));
    vq.push_back(mk(0,1,1,0,0,9, 4,0,0,0));   // stop beats start
    vq.push_back(mk(0,1,0,0,0,5, 5,1,0,0));
    vq.push_back(mk(1,1,0,0,0,7, 7,1,0,0));   // restart ignores same-cycle tick
    vq.push_back(mk(0,0,0,0,0,0, 7,1,0,0));
    vq.push_back(mk(0,1,0,0,0,0, 0,1,0,0));   // load_val = 0
    vq.push_back(mk(1,0,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,1));
    vq.push_back(mk(0,0,1,0,0,0, 0,0,0,1));   // stop from DONE keeps expired
    vq.push_back(mk(0,0,0,1,0,0, 0,0,0,0));   // clear in IDLE
    vq.push_back(mk(0,1,0,0,1,255, 255,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 254,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0, 254,0,0,0));
    for (int i = 0; vq.size() > 0; i++) begin
      drive(vq.pop_front());
      e = sb.pop_front();
      vectors++;
      if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
        miscompares++;
        $display("FAIL simultaneous step %0d: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
                 i, count, running, done, expired, e.count, e.running, e.done, e.expired);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    vq.push_back(mk(0,1,0,0,0,5, 5,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 4,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 4,1,0,0));
    while (vq.size() > 0) begin
      drive(vq.pop_front());
      void'(sb.pop_front());
    end
    tc_in = 1'b1;
    rst_n = 1'b0;
    #1;
    e.count = '0; e.running = 0; e.done = 0; e.expired = 0;
    sb.push_back(e);
    e = sb.pop_front();
    vectors++;
    if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
      miscompares++;
      $display("FAIL reset_mid async: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
               count, running, done, expired, e.count, e.running, e.done, e.expired);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(1,1,0,0,0,3, 3,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 3,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 3,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 3,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 2,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0, 2,0,0,0));
    for (int i = 0; vq.size() > 0; i++) begin
      drive(vq.pop_front());
      e = sb.pop_front();
      vectors++;
      if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
        miscompares++;
        $display("FAIL reset_mid step %0d: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
                 i, count, running, done, expired, e.count, e.running, e.done, e.expired);
      end
    end
  endtask

  task automatic test_start_from_done();
    exp_t e;
    vq.push_back(mk(0,1,0,0,0,1, 1,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,1));
    vq.push_back(mk(0,1,0,0,1,9, 9,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 8,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0, 8,0,0,0));
    for (int i = 0; vq.size() > 0; i++) begin
      drive(vq.pop_front());
      e = sb.pop_front();
      vectors++;
      if ({count, running, done, expired} !== {e.count, e.running, e.done, e.expired}) begin
        miscompares++;
        $display("FAIL start_from_done step %0d: count=%0d run=%0b done=%0b exp=%0b, expected count=%0d run=%0b done=%0b exp=%0b",
                 i, count, running, done, expired, e.count, e.running, e.done, e.expired);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_stall();
    test_simultaneous();
    test_reset_mid();
    test_start_from_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
